updown_sel_counter: RTL
=======================

Name: updown_sel_counter

Overview:
Parametrised up/down selection counter driven by user push-buttons. It generalises the fixed 0..10 option counter to a configurable range, wrap/saturate mode, synchronous load and hold-to-repeat. Sits between the debounced button inputs and the option/mux select logic. Inputs are already synchronised and debounced upstream.

Parameters:
- WIDTH, 4, count width in bits.
- MIN_VAL, 0, lowest count value.
- MAX_VAL, 10, highest count value. Must satisfy MIN_VAL < MAX_VAL < 2**WIDTH.
- RST_VAL, 0, count value after reset. Must satisfy MIN_VAL <= RST_VAL <= MAX_VAL.
- HOLD_CYCLES, 50000000, cycles a button is held after its first step before auto-repeat starts.
- REPEAT_CYCLES, 10000000, cycles between auto-repeat steps.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous reset, active-high.
- enable, in, 1, stepping enable.
- up, in, 1, increment button, level.
- down, in, 1, decrement button, level.
- wrap_en, in, 1, 1 = wrap at the range ends, 0 = saturate.
- load, in, 1, synchronous load strobe.
- load_val, in, WIDTH, value to load.
- count, out, WIDTH, current selection (registered).
- at_min, out, 1, count == MIN_VAL (combinational from count).
- at_max, out, 1, count == MAX_VAL (combinational from count).
- changed, out, 1, one-cycle registered pulse when count changes value.

Behaviour:
- Reset: rst is synchronous and active-high on clk. It sets count=RST_VAL, changed=0, both key FSMs to IDLE, and the timers to 0.
- Key FSM per direction (states IDLE, WAIT_HOLD, REPEAT, LOCKED):
  - IDLE -> WAIT_HOLD when the button is sampled 1. This issues one step request on that same edge, so count updates at that edge with no extra latency.
  - WAIT_HOLD: the timer counts while the button is held. At HOLD_CYCLES it issues a step and goes to REPEAT.
  - REPEAT: issues a step every REPEAT_CYCLES while the button is held.
  - Any state -> IDLE when the button is 0. The timer clears.
  - LOCKED: no steps are issued. Exits to IDLE only when the button is released.
- Simultaneous up and down: neither step is applied. Both FSMs go to LOCKED.
- enable=0: no steps and count holds. Any FSM whose button is high goes to LOCKED, so a fresh press is required after enable returns to 1.
- Step arithmetic:
  - Up at MAX_VAL gives MIN_VAL if wrap_en=1, otherwise stays MAX_VAL.
  - Down at MIN_VAL gives MAX_VAL if wrap_en=1, otherwise stays MIN_VAL.
  - All other steps are count ±1.
- Load has priority over steps in the same cycle. load_val is clamped into [MIN_VAL, MAX_VAL]. Load ignores enable. The key FSMs are unaffected by load.
- A count outside the range can never occur. Any out-of-range value is forced to RST_VAL on the next edge.
- changed=1 for exactly one cycle after an edge where count took a new value. It stays 0 on saturated or no-op steps and on a load of the current value.
- Reset mid-hold: the FSMs return to IDLE. If the button is still high after rst drops, that counts as a new press.

Optional Feature:
AUTOREPEAT_EN.
- Defined: full WAIT_HOLD/REPEAT behaviour as above.
- Undefined: the repeat timers are not built. The FSM goes IDLE -> LOCKED after the first step, giving exactly one step per press, which matches the legacy behaviour. HOLD_CYCLES and REPEAT_CYCLES are ignored.

Decomposition:
- Package updown_sel_pkg: key-state enum (IDLE, WAIT_HOLD, REPEAT, LOCKED), step-direction encoding (STEP_NONE, STEP_UP, STEP_DN), and a function computing the timer width clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1).
- Sub-module key_repeat_fsm: one instance per direction. Inputs are button, lock_req and enable. Output is a step pulse. It contains the state register and timer.
- The top level holds arbitration, the range arithmetic, load clamping and the changed/at_* outputs.

Test Plan (WIDTH=4, MIN=0, MAX=10, RST=0, HOLD=8, REPEAT=4, AUTOREPEAT_EN defined):
1. Reset, then pulse up 3 times, each 2 cycles high and 2 low -> count 1, 2, 3; changed pulses 3 times.
2. wrap_en=1, load 10, pulse up -> count 0. wrap_en=0, load 0, pulse down -> count stays 0, changed=0, at_min=1.
3. Hold up for 20 cycles from count 0 -> steps at cycles 0, 8, 12, 16 -> count 4. Release -> count holds.
4. up and down high together from count 5 -> count stays 5. Release down only -> up stays LOCKED, no step. Release up and press again -> count 6.
5. load=1 with load_val=15 while up is pressed -> count 10 (clamped, load wins). enable=0 with up held -> no step; enable back to 1 -> still no step until up is released and pressed again.
6. rst asserted during REPEAT with up held -> count 0. rst released with up still high -> one step to 1 on that edge.

Source files
------------

// File: rtl/updown_sel_counter_pkg.sv
// Shared types for the up/down selection counter: key FSM states, step
// direction and the repeat-timer width helper.
package updown_sel_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT, LOCKED} key_state_e;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN} step_dir_e;

  // Bits needed to count up to the longer of the two repeat intervals.
  function automatic int timer_w(input int hold, input int rpt);
    int m;
    m = (hold > rpt) ? hold : rpt;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/updown_sel_counter_if.sv
// Button/select bus of the up/down selection counter.
// master = button/host side, slave = the counter.
interface updown_sel_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up;
  logic             down;
  logic             wrap_en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             at_min;
  logic             at_max;
  logic             changed;

  modport master (
    output enable, up, down, wrap_en, load, load_val,
    input  count, at_min, at_max, changed
  );

  modport slave (
    input  enable, up, down, wrap_en, load, load_val,
    output count, at_min, at_max, changed
  );
endinterface

// File: rtl/updown_sel_counter_key_repeat_fsm.sv
// Per-button press/hold/repeat FSM producing step pulses.
// AUTOREPEAT_EN: build hold/repeat timers; otherwise one step per press.
module key_repeat_fsm
  import updown_sel_pkg::*;
#(
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic lock_req_i,
  input  logic enable_i,
  output logic step_o
);

  key_state_e state_q;
  logic       go;

  // Step is issued on the sampling edge itself, so it is decoded from state.
  assign go = btn_i && !lock_req_i && enable_i;

`ifdef AUTOREPEAT_EN
  localparam int            TW        = timer_w(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RPT_LAST  = TW'(REPEAT_CYCLES - 1);

  logic [TW-1:0] timer_q;

  always_ff @(posedge clk) begin
    if (rst || !btn_i) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else if (lock_req_i || !enable_i) begin
      state_q <= LOCKED;
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= WAIT_HOLD;
          timer_q <= '0;
        end
        WAIT_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_q <= REPEAT;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        REPEAT: begin
          if (timer_q == RPT_LAST) timer_q <= '0;
          else                     timer_q <= timer_q + TW'(1);
        end
        default: timer_q <= '0;
      endcase
    end
  end

  always_comb begin
    step_o = 1'b0;
    if (go) begin
      case (state_q)
        IDLE:      step_o = 1'b1;
        WAIT_HOLD: step_o = (timer_q == HOLD_LAST);
        REPEAT:    step_o = (timer_q == RPT_LAST);
        default:   step_o = 1'b0;
      endcase
    end
  end
`else
  localparam int unused_cfg = HOLD_CYCLES + REPEAT_CYCLES;

  always_ff @(posedge clk) begin
    if (rst || !btn_i)                  state_q <= IDLE;
    else if (lock_req_i || !enable_i)   state_q <= LOCKED;
    else if (state_q == IDLE)           state_q <= LOCKED;
  end

  assign step_o = go && (state_q == IDLE);
`endif

endmodule

// File: rtl/updown_sel_counter.sv
// Up/down selection counter: key arbitration, range/wrap arithmetic, load clamp.
// AUTOREPEAT_EN enables hold-to-repeat in the key FSMs.
module updown_sel_counter
  import updown_sel_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 10,
  parameter int RST_VAL       = 0,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input logic                clk,
  input logic                rst,
  updown_sel_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);

  logic [1:0]       btn, step;
  step_dir_e        dir;
  logic [WIDTH-1:0] count_q, count_d, load_clamped;
  logic             changed_q, changed_d;
  logic             in_range;

  // bit 0 = up, bit 1 = down; each key is locked out by the other.
  assign btn = {bus.down, bus.up};

  for (genvar d = 0; d < 2; d++) begin : g_key
    key_repeat_fsm #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_key (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn[d]),
      .lock_req_i(btn[1-d]),
      .enable_i  (bus.enable),
      .step_o    (step[d])
    );
  end

  always_comb begin
    case (step)
      2'b01:   dir = STEP_UP;
      2'b10:   dir = STEP_DN;
      default: dir = STEP_NONE;
    endcase
  end

  assign in_range = (int'(count_q) >= MIN_VAL) && (int'(count_q) <= MAX_VAL);

  always_comb begin
    if (int'(bus.load_val) < MIN_VAL)      load_clamped = MIN_C;
    else if (int'(bus.load_val) > MAX_VAL) load_clamped = MAX_C;
    else                                   load_clamped = bus.load_val;
  end

  always_comb begin
    count_d = count_q;
    if (!in_range) begin
      count_d = RST_C;
    end else if (bus.load) begin
      count_d = load_clamped;
    end else begin
      case (dir)
        STEP_UP: count_d = (count_q == MAX_C) ? (bus.wrap_en ? MIN_C : MAX_C)
                                              : count_q + WIDTH'(1);
        STEP_DN: count_d = (count_q == MIN_C) ? (bus.wrap_en ? MAX_C : MIN_C)
                                              : count_q - WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
    changed_d = (count_d != count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= RST_C;
      changed_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      changed_q <= changed_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.changed = changed_q;
  assign bus.at_min  = (count_q == MIN_C);
  assign bus.at_max  = (count_q == MAX_C);

endmodule
